// File: rtl/wb_master_rdwr_controller_if.sv
// Wishbone classic bus bundle between the single-transfer master and its slaves.
interface wb_master_rdwr_controller_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] wbs_adr_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_we_o;
    logic              wbs_stb_o;
    logic              wbs_cyc_o;
    logic              wbs_ack_i;

    modport master (
        output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_stb_o, wbs_cyc_o,
        input  wbs_dat_i, wbs_ack_i
    );

    modport slave (
        input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_stb_o, wbs_cyc_o,
        output wbs_dat_i, wbs_ack_i
    );
endinterface

// File: rtl/wb_master_rdwr_controller.sv
// Wishbone classic single-transfer master: one request pulse becomes one bus
// cycle, finished by ack or by an optional ack timeout.
module wb_master_rdwr_controller #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    wb_master_rdwr_controller_if.master        wb,
    input  logic                               read,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [DATA_W-1:0]                  data_in,
    output logic [DATA_W-1:0]                  data_out,
    output logic                               data_out_valid,
    output logic                               done,
    output logic                               timeout_err,
    output logic                               busy
);
    // TIMEOUT=0 still needs a 1-bit counter so the declaration stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUS} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] adr, adr_n;
    logic [DATA_W-1:0] dat, dat_n, dout_n;
    logic              we, we_n, stb_n, cyc_n, stb, cyc;
    logic              dvalid_n, done_n, terr_n, busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            adr            <= '0;
            dat            <= '0;
            we             <= 1'b0;
            stb            <= 1'b0;
            cyc            <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            adr            <= adr_n;
            dat            <= dat_n;
            we             <= we_n;
            stb            <= stb_n;
            cyc            <= cyc_n;
            data_out       <= dout_n;
            data_out_valid <= dvalid_n;
            done           <= done_n;
            timeout_err    <= terr_n;
            busy           <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        adr_n    = adr;
        dat_n    = dat;
        we_n     = we;
        stb_n    = stb;
        cyc_n    = cyc;
        dout_n   = data_out;
        dvalid_n = 1'b0;
        done_n   = 1'b0;
        terr_n   = 1'b0;
        busy_n   = busy;
        case (state)
            IDLE: begin
                // The done cycle is already IDLE; holding off one more cycle
                // keeps requests overlapping completion from being taken.
                if ((read || write) && !done) begin
                    state_n = BUS;
                    cnt_n   = '0;
                    adr_n   = address;
                    dat_n   = data_in;
                    we_n    = write;
                    stb_n   = 1'b1;
                    cyc_n   = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            BUS: begin
                if (wb.wbs_ack_i || (TIMEOUT != 0 && cnt == CNT_LAST)) begin
                    state_n = IDLE;
                    adr_n   = '0;
                    dat_n   = '0;
                    we_n    = 1'b0;
                    stb_n   = 1'b0;
                    cyc_n   = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    if (wb.wbs_ack_i) begin
                        if (!we) begin
                            dout_n   = wb.wbs_dat_i;
                            dvalid_n = 1'b1;
                        end
                    end else begin
                        terr_n = 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign wb.wbs_adr_o = adr;
    assign wb.wbs_dat_o = dat;
    assign wb.wbs_we_o  = we;
    assign wb.wbs_stb_o = stb;
    assign wb.wbs_cyc_o = cyc;
endmodule

// File: tb/tb_wb_master_rdwr_controller.sv
// Bench for wb_master_rdwr_controller: directed cases then random transfers,
// each checked against a transaction-level timing model.
module tb_wb_master_rdwr_controller;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          read, write;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, data_out;
    logic          data_out_valid, done, timeout_err, busy;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_dout;

    always #5 clk = ~clk;

    wb_master_rdwr_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_master_rdwr_controller #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .wb(bus),
        .read(read), .write(write), .address(address), .data_in(data_in),
        .data_out(data_out), .data_out_valid(data_out_valid), .done(done),
        .timeout_err(timeout_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cyc"},   DW'(bus.wbs_cyc_o), '0);
        chk({tag, ".stb"},   DW'(bus.wbs_stb_o), '0);
        chk({tag, ".busy"},  DW'(busy), '0);
        chk({tag, ".done"},  DW'(done), '0);
        chk({tag, ".dval"},  DW'(data_out_valid), '0);
        chk({tag, ".terr"},  DW'(timeout_err), '0);
        chk({tag, ".dout"},  data_out, exp_dout);
    endtask

    // d = stb cycles before the slave acks (ack in stb cycle d+1); d >= TO never acks.
    task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] din, input int d,
                        input logic [DW-1:0] rdata, input bit noise);
        bit is_wr = wr;
        bit acked = (d < TO);
        int e     = acked ? d + 2 : TO + 1;
        read = rd; write = wr; address = a; data_in = din;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; address = AW'($urandom); data_in = $urandom;
        for (int j = 1; j < e; j++) begin
            chk("bus.cyc",  DW'(bus.wbs_cyc_o), DW'(1));
            chk("bus.stb",  DW'(bus.wbs_stb_o), DW'(1));
            chk("bus.adr",  DW'(bus.wbs_adr_o), DW'(a));
            chk("bus.we",   DW'(bus.wbs_we_o),  DW'(is_wr));
            if (is_wr) chk("bus.dat", bus.wbs_dat_o, din);
            chk("bus.busy", DW'(busy), DW'(1));
            chk("bus.done", DW'(done), '0);
            bus.wbs_dat_i = $urandom;
            bus.wbs_ack_i = (j - 1 == d);
            if (j - 1 == d) bus.wbs_dat_i = rdata;
            if (noise) begin read = 1'($urandom); write = 1'($urandom); end
            @(posedge clk); #1;
            bus.wbs_ack_i = 1'b0; read = 1'b0; write = 1'b0;
        end
        if (acked && !is_wr) exp_dout = rdata;
        chk("end.done", DW'(done), DW'(1));
        chk("end.terr", DW'(timeout_err), DW'(!acked));
        chk("end.dval", DW'(data_out_valid), DW'(acked && !is_wr));
        chk("end.dout", data_out, exp_dout);
        chk("end.cyc",  DW'(bus.wbs_cyc_o), '0);
        chk("end.stb",  DW'(bus.wbs_stb_o), '0);
        chk("end.we",   DW'(bus.wbs_we_o), '0);
        chk("end.adr",  DW'(bus.wbs_adr_o), '0);
        chk("end.busy", DW'(busy), '0);
        // A request during the done cycle must be dropped.
        if (noise) write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        chk_idle("post");
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_in = '0;
        bus.wbs_ack_i = 1'b0; bus.wbs_dat_i = '0;
        exp_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle("rst");
        chk("rst.adr", DW'(bus.wbs_adr_o), '0);
        chk("rst.dat", bus.wbs_dat_o, '0);
        chk("rst.we",  DW'(bus.wbs_we_o), '0);

        // Write with late ack, fastest read, held data across a write.
        xfer(1'b0, 1'b1, 7'd5, 32'hA7, 2, '0, 1'b0);
        xfer(1'b1, 1'b0, 7'd2, '0, 0, 32'h3C, 1'b0);
        xfer(1'b0, 1'b1, 7'd1, 32'h55, 1, '0, 1'b0);
        // Timeout, then ack exactly on the expiry edge.
        xfer(1'b0, 1'b1, 7'd3, 32'h11, TO + 3, '0, 1'b0);
        xfer(1'b1, 1'b0, 7'd4, '0, TO - 1, 32'h99, 1'b0);
        // Both ops together plus requests while busy and during done.
        xfer(1'b1, 1'b1, 7'd6, 32'h42, 1, 32'h77, 1'b1);

        // Reset in the middle of a bus cycle.
        read = 1'b0; write = 1'b1; address = 7'd9; data_in = 32'h1;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dout = '0;
        chk_idle("midrst");
        @(posedge clk); #1;
        chk_idle("midrst2");

        // Stray ack while idle.
        bus.wbs_ack_i = 1'b1; bus.wbs_dat_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.wbs_ack_i = 1'b0;
        chk_idle("stray");
        chk("stray.adr", DW'(bus.wbs_adr_o), '0);

        // Full-width write and read-back.
        xfer(1'b0, 1'b1, 7'h7F, 32'hDEADBEEF, 1, '0, 1'b0);
        xfer(1'b1, 1'b0, 7'h7F, '0, 0, 32'hDEADBEEF, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic r, w;
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) w = 1'b1;
            xfer(r, w, AW'($urandom), $urandom, int'($urandom_range(0, TO + 2)),
                 $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
